ram_march_driver: RTL and testbench
===================================

# ram_march_driver

Stimulus end of the RAM test datapath. Sequences a four-pass write/read-back test over every RAM address and drives the RAM address, write data and write enable. Presents the expected read value aligned with the RAM's read data so both feed the downstream error-check pipeline together. Counts the error pulses that return from that pipeline, using matching latency, into a saturating failure count.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width; the test covers 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, RAM word width.
- READ_LATENCY, 2, cycles from read address issued to RAM read data valid; must be ≥1.
- CHECK_LATENCY, 3, cycles from the checker sampling read/expected to its error output reflecting them; must be ≥1.
- FAIL_COUNT_WIDTH, 16, width of the failure counter.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin test; sampled only in IDLE or DONE.
- ram_addr, output, ADDR_WIDTH, RAM address; registered.
- ram_wdata, output, DATA_WIDTH, RAM write data; registered.
- ram_we, output, 1, RAM write enable; registered.
- expected, output, DATA_WIDTH, expected read value to the checker; registered.
- error, input, 1, mismatch flag from the checker.
- busy, output, 1, high from the first WRITE cycle through the last DRAIN cycle.
- done, output, 1, high in DONE until the next accepted start.
- pass, output, 2, current pass index (0–3).
- fail_count, output, FAIL_COUNT_WIDTH, number of counted mismatches; saturating.

## Operation
- Reset: all outputs are 0 and the FSM is in IDLE. Asserting reset mid-test aborts the test and clears all in-flight pipeline state.
- FSM states: IDLE → WRITE → READ → DRAIN → (WRITE of the next pass | DONE).
  - IDLE/DONE with start=1: clear fail_count, set pass=0, enter WRITE. start is ignored while busy.
  - WRITE: one word per cycle at ram_addr = 0 .. 2^ADDR_WIDTH−1 with ram_we=1. After the last address, go to READ with ram_addr=0.
  - READ: one read per cycle at ram_addr = 0 .. 2^ADDR_WIDTH−1 with ram_we=0. After the last address, go to DRAIN.
  - DRAIN: exactly READ_LATENCY+CHECK_LATENCY cycles. Then, if pass<3, increment pass and enter WRITE; otherwise enter DONE.
- Pattern for pass p at address a (DATA_WIDTH bits):
  - p0: alternating bits 0101…, LSB = 1 (0x55 for width 8).
  - p1: complement of p0 (0xAA).
  - p2: a, zero-extended or truncated to DATA_WIDTH.
  - p3: bitwise complement of p2.
- ram_wdata is 0 outside WRITE. expected is 0 when no read is in the slot that is arriving.
- Read tracking: each READ cycle pushes {valid, pattern} into a READ_LATENCY-deep shift register. The output stage drives expected, and its valid bit feeds a CHECK_LATENCY-deep valid shift register.
- Counting: fail_count increments when error=1 and the check-valid tap is 1.
  - error is ignored in every other cycle.
  - At all-ones, fail_count holds.
- pass and fail_count hold their final values in DONE.

## Timing
- start accepted at edge E: busy=1 and ram_we=1 with ram_addr=0 in the cycle after E.
- A read issued in cycle t has its expected value driven during cycle t+READ_LATENCY, the same cycle the RAM presents its data.
- The error for that read is sampled in cycle t+READ_LATENCY+CHECK_LATENCY. For the last read of a pass, this is the final DRAIN cycle.
- Busy cycles per test: 4·(2·2^ADDR_WIDTH + READ_LATENCY + CHECK_LATENCY). This is 2068 cycles at the default parameters.
- done rises, and busy falls, on the cycle after the final DRAIN cycle.
- Back-to-back: start held high in DONE restarts immediately, and done falls on the same edge busy rises.

## Test plan
- Ideal RAM model, default parameters, start pulse → fail_count=0; done rises exactly 2068 cycles after busy rises; ram_wdata in pass 0 is 0x55 and in pass 3 at address 0x12 is 0xED.
- RAM model with data bit 0 stuck at 0 → fail_count=512 (256 in p0, 0 in p1, 128 in p2, 128 in p3).
- RAM model that flips bit 7 on reads of address 0x3C only → fail_count=4, with increments exactly READ_LATENCY+CHECK_LATENCY cycles after each read of 0x3C.
- error forced to 1 in every cycle while idle and during WRITE phases, with an ideal RAM → fail_count=0 (only check-valid slots count).
- FAIL_COUNT_WIDTH=4 with bit 0 stuck at 0 → fail_count saturates at 15 and stays 15.
- reset_n pulsed low mid-READ of pass 1 → all outputs 0 and IDLE; a new start runs a clean 2068-cycle test with fail_count=0. A start pulsed while busy has no effect.

Source files
------------

// File: rtl/ram_march_driver.sv
// rtl/ram_march_driver.sv - four-pass RAM march sequencer with aligned expected data and failure counting
// Walks WRITE/READ/DRAIN per pass; read slots travel through valid pipelines so error pulses are only counted for real reads.
module ram_march_driver #(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int READ_LATENCY     = 2,
  parameter int CHECK_LATENCY    = 3,
  parameter int FAIL_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wdata,
  output logic                        ram_we,
  output logic [DATA_WIDTH-1:0]       expected,
  input  logic                        error,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  pass,
  output logic [FAIL_COUNT_WIDTH-1:0] fail_count
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int DRAIN_CYCLES = READ_LATENCY + CHECK_LATENCY;
  localparam int DCW          = $clog2(DRAIN_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [DCW-1:0]        LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

  state_t                        state_q;
  logic [ADDR_WIDTH-1:0]         ram_addr_q;
  logic [DATA_WIDTH-1:0]         ram_wdata_q;
  logic                          ram_we_q;
  logic                          busy_q;
  logic                          done_q;
  logic [1:0]                    pass_q;
  logic [FAIL_COUNT_WIDTH-1:0]   fail_count_q;
  logic [DCW-1:0]                drain_cnt_q;
  logic [DATA_WIDTH-1:0]         rd_data_q  [READ_LATENCY];
  logic                          rd_valid_q [READ_LATENCY];
  logic                          chk_valid_q[CHECK_LATENCY];

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] p,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] alt;
    logic [DATA_WIDTH-1:0] addr_ext;
    for (int i = 0; i < DATA_WIDTH; i++) alt[i] = (i % 2 == 0);
    addr_ext = DATA_WIDTH'(a);
    case (p)
      2'd0:    return alt;
      2'd1:    return ~alt;
      2'd2:    return addr_ext;
      default: return ~addr_ext;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 2'd0;
      fail_count_q <= '0;
      drain_cnt_q  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        rd_data_q[k]  <= '0;
        rd_valid_q[k] <= 1'b0;
      end
      for (int k = 0; k < CHECK_LATENCY; k++) chk_valid_q[k] <= 1'b0;
    end else begin
      // Read slot pipeline: the last stage is the expected value itself.
      rd_valid_q[0] <= (state_q == S_READ);
      rd_data_q[0]  <= (state_q == S_READ) ? pattern(pass_q, ram_addr_q) : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        rd_valid_q[k] <= rd_valid_q[k-1];
        rd_data_q[k]  <= rd_data_q[k-1];
      end
      chk_valid_q[0] <= rd_valid_q[READ_LATENCY-1];
      for (int k = 1; k < CHECK_LATENCY; k++) chk_valid_q[k] <= chk_valid_q[k-1];

      if (error && chk_valid_q[CHECK_LATENCY-1] && (fail_count_q != '1))
        fail_count_q <= fail_count_q + 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_WRITE;
            pass_q       <= 2'd0;
            fail_count_q <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b1;
            ram_wdata_q  <= pattern(2'd0, '0);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_WRITE: begin
          if (ram_addr_q == LAST_ADDR) begin
            state_q     <= S_READ;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
          end else begin
            ram_addr_q  <= ram_addr_q + 1'b1;
            ram_wdata_q <= pattern(pass_q, ram_addr_q + 1'b1);
          end
        end
        S_READ: begin
          if (ram_addr_q == LAST_ADDR) begin
            state_q     <= S_DRAIN;
            ram_addr_q  <= '0;
            drain_cnt_q <= '0;
          end else begin
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == LAST_DRAIN) begin
            if (pass_q != 2'd3) begin
              state_q     <= S_WRITE;
              pass_q      <= pass_q + 2'd1;
              ram_addr_q  <= '0;
              ram_we_q    <= 1'b1;
              ram_wdata_q <= pattern(pass_q + 2'd1, '0);
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign expected   = rd_data_q[READ_LATENCY-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_ram_march_driver.sv
// tb/tb_ram_march_driver.sv - scoreboard bench for ram_march_driver with a behavioural RAM and checker
// A narrow-counter second instance shares all inputs to observe saturation.
module tb_ram_march_driver;

  localparam int RL   = 2;
  localparam int CL   = 3;
  localparam int SPAN = 2068;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  ram_addr, ram_wdata, expected;
  logic        ram_we, error, busy, done;
  logic [1:0]  pass;
  logic [15:0] fail_count;
  logic [7:0]  u4_addr, u4_wdata, u4_exp;
  logic        u4_we, u4_busy, u4_done;
  logic [1:0]  u4_pass;
  logic [3:0]  u4_fail;

  ram_march_driver dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .expected(expected), .error(error), .busy(busy), .done(done),
    .pass(pass), .fail_count(fail_count)
  );

  ram_march_driver #(.FAIL_COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .ram_addr(u4_addr), .ram_wdata(u4_wdata),
    .ram_we(u4_we), .expected(u4_exp), .error(error), .busy(u4_busy), .done(u4_done),
    .pass(u4_pass), .fail_count(u4_fail)
  );

  always #5 clk = ~clk;

  // Behavioural RAM (mode 0 ideal, 1 bit0 stuck low, 2 bit7 flipped on reads of 0x3C) and checker.
  int         mode;
  bit         force_err;
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [RL];
  logic       chk_pipe [CL];

  function automatic logic [7:0] ram_read(input logic [7:0] a);
    logic [7:0] d;
    d = mem[a];
    if (mode == 1) d[0] = 1'b0;
    if (mode == 2 && a == 8'h3C) d[7] = ~d[7];
    return d;
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_read(ram_addr);
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    chk_pipe[0] <= (rd_pipe[RL-1] != expected);
    for (int k = 1; k < CL; k++) chk_pipe[k] <= chk_pipe[k-1];
  end

  assign error = (force_err && (!busy || ram_we)) ? 1'b1 : chk_pipe[CL-1];

  typedef struct { int fc; int fc4; } exp_t;
  exp_t exp_q[$];
  int   inc_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard at each falling edge.
  initial begin : monitor
    exp_t        e;
    logic        busy_prev = 1'b0, done_prev = 1'b0;
    logic [15:0] fail_prev = '0;
    int          busy_rise_cyc = 0;
    logic [7:0]  pat12 [4];
    pat12 = '{8'h55, 8'hAA, 8'h12, 8'hED};
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        check("reset_outputs", {ram_addr, ram_wdata, ram_we, expected, busy, done, pass, fail_count, u4_fail}, 64'd0);
        busy_prev = 1'b0; done_prev = 1'b0; fail_prev = '0;
        inc_q.delete();
      end else begin
        if (busy && !busy_prev) begin
          busy_rise_cyc = cyc;
          check("start_we", ram_we, 1);
          check("start_addr", ram_addr, 0);
          check("start_wdata_p0", ram_wdata, 8'h55);
          check("start_pass_done_fail", {pass, done, fail_count}, 0);
        end
        if (ram_we && ram_addr == 8'h12) check("wdata_at_0x12", ram_wdata, pat12[pass]);
        if (mode == 2 && busy && !ram_we && ram_addr == 8'h3C) inc_q.push_back(cyc + RL + CL + 1);
        if (mode == 2 && fail_count == fail_prev + 16'd1) begin
          if (inc_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL inc_unexpected: got increment at cycle %0d, expected none", cyc);
          end else check("inc_timing", cyc, inc_q.pop_front());
        end
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_unexpected: got done at cycle %0d, expected no pending test", cyc);
          end else begin
            e = exp_q.pop_front();
            check("fail_count", fail_count, e.fc);
            check("fail_count_w4", u4_fail, e.fc4);
            check("final_pass", pass, 3);
            check("busy_low_at_done", busy, 0);
            check("busy_span", cyc - busy_rise_cyc, SPAN);
          end
        end
        busy_prev = busy; done_prev = done; fail_prev = fail_count;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input int fc, input int fc4);
    exp_t e;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e.fc = fc; e.fc4 = fc4;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (done) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s_timeout: got no done within 3000 cycles, expected done", name);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish by 1 ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit hit;
    reset_n = 1'b0; start = 1'b0; mode = 0; force_err = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    go(0, 0);                 // ideal RAM
    wait_done("ideal");

    mode = 1;                 // back-to-back restart, bit 0 stuck low
    go(512, 15);
    wait_done("stuck");
    tick(10);

    mode = 2;                 // bit 7 flipped on reads of 0x3C
    go(4, 4);
    wait_done("flip");
    tick(4);

    mode = 0; force_err = 1'b1;
    tick(4);
    go(0, 0);
    wait_done("forced_error");
    force_err = 1'b0;
    tick(3);

    start = 1'b1;             // aborted run: no scoreboard entry
    tick(1);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick(1);
      hit = (pass == 2'd1 && busy && !ram_we && ram_addr == 8'h40);
    end
    check("reach_pass1_read", hit, 1);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    go(0, 0);
    tick(100);
    start = 1'b1;             // ignored while busy
    tick(1);
    start = 1'b0;
    wait_done("after_reset");
    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
